mini_tpu_core: RTL
==================

Name: mini_tpu_core

Overview:
- Parametrised, self-contained matrix-multiply engine: a sequencer plus an N×N output-stationary MAC array.
- Computes C = A·B, with A, B and C all N×N.
- Operands arrive over a single valid/ready byte stream: weights B first, then activations A.
- Results leave over a valid/ready stream with backpressure. An accumulate mode adds a new product onto the previous results. Sits between the host stream interface and the output SRAM writer.

Parameters:
- N, 4, array dimension; also the inner dimension K (N ≥ 2).
- DATA_W, 8, operand width; unsigned.
- ACC_W, 24, accumulator and result width; arithmetic wraps modulo 2^ACC_W.
- IDX_W, $clog2(N*N), width of out_index.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin an operation; sampled only in IDLE.
- accumulate  in  1  sampled with start. 1 = add onto existing C; 0 = clear C first.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last result transfers.
- in_data  in  DATA_W  operand byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  core accepts in_data this cycle.
- out_data  out  ACC_W  result C[i][j].
- out_index  out  IDX_W  i*N+j of out_data.
- out_valid  out  1  out_data/out_index valid.
- out_ready  in  1  consumer accepts the result.

Behaviour:
- Reset values: state = IDLE; busy, done, in_ready, out_valid = 0; out_data, out_index = 0; all accumulators and operand registers = 0; counters = 0.
- States: IDLE → LOAD_W → LOAD_A → COMPUTE → DRAIN → DONE → IDLE.
- IDLE:
  - start=1 latches accumulate into acc_mode_q; next state LOAD_W.
  - start is ignored in every other state.
- LOAD_W:
  - in_ready = 1. A transfer is in_valid && in_ready.
  - Transfers fill B[k][j] in row-major order (k outer, j inner), N*N words.
  - The cycle of the N*N-th transfer moves the core to LOAD_A.
  - Gaps in in_valid stall; there is no timeout.
- LOAD_A:
  - in_ready = 1. Transfers fill A[i][k] in row-major order, N*N words.
  - The N*N-th transfer moves the core to COMPUTE.
  - On that same edge, all accumulators clear to 0 if acc_mode_q == 0; otherwise they hold.
- COMPUTE:
  - in_ready = 0. Lasts exactly 3N-2 cycles, counter t = 0..3N-3.
  - At cycle t, PE(i,j) performs acc += A[i][k]*B[k][j] with k = t-i-j, only when 0 ≤ k < N. This is skewed systolic timing.
  - Product width is 2*DATA_W, zero-extended to ACC_W, then summed modulo 2^ACC_W (no saturation).
  - Moves to DRAIN after t = 3N-3.
- DRAIN:
  - out_valid = 1; out_index counts 0..N*N-1 row-major; out_data = C[out_index/N][out_index%N].
  - out_data and out_index stay stable while out_valid && !out_ready.
  - Index advances only on out_valid && out_ready.
  - The transfer at index N*N-1 moves the core to DONE; out_valid drops on the next cycle.
- DONE: done = 1 for exactly one cycle, then IDLE. busy = 0 starting in IDLE.
- Accumulators persist across operations until rst or a start with accumulate=0.
- Latency with in_valid and out_ready held high, counted from the start edge to done high: 1 + 2N² + (3N-2) + N² cycles. For N=4 this is 59.
- rst in any state returns everything to reset values on the next edge. A partial load or partial drain is discarded.
- No simultaneous-event ambiguity:
  - in_ready and out_valid are never both high.
  - start during busy has no effect and is not queued.

Test Plan:
- Identity weights: N=4, B = identity, A = 1..16 row-major, accumulate=0 → results C = 1..16 at out_index 0..15, in order. done pulses exactly once, 59 cycles after start with no stalls.
- Accumulate: repeat the same operation with accumulate=1 → C[i][j] = 2*A[i][j] (2,4,...,32). A third run with accumulate=0 → back to 1..16.
- Backpressure and input gaps: random in_valid (50%) and out_ready toggling every other cycle → identical results. out_data/out_index never change while out_valid && !out_ready; exactly 32 input transfers and 16 output transfers.
- Wrap-around: ACC_W=16, A = B = all 255 → every C = 4*65025 mod 65536 = 63492.
- Reset mid-operation: assert rst at COMPUTE cycle t=3 → next cycle busy=0, out_valid=0, accumulators 0. A following run with accumulate=1 and identity B gives C = A (no residue from the aborted run).
- start while busy: pulse start during LOAD_A and during DRAIN → no state change, no extra done. Exactly one done per accepted start.

Source files
------------

// File: rtl/mini_tpu_core.sv
// Matrix-multiply engine: streams in B then A, runs an N x N output-stationary
// MAC array with skewed systolic timing, then drains C over a valid/ready stream.
module mini_tpu_core #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int IDX_W  = $clog2(N*N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              accumulate,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_valid,
  input  logic              out_ready
);
  localparam int NN = N * N;
  localparam int PW = 2 * DATA_W;
  localparam int T_W = $clog2(3 * N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);
  localparam logic [T_W-1:0]   LAST_T   = T_W'(3 * N - 3);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_LOAD_A, S_COMPUTE, S_DRAIN, S_DONE
  } state_t;

  state_t            r_state;
  logic              r_acc_mode;
  logic [IDX_W-1:0]  r_cnt;
  logic [T_W-1:0]    r_t;
  logic [DATA_W-1:0] r_a [NN];
  logic [DATA_W-1:0] r_b [NN];
  logic [ACC_W-1:0]  r_acc [NN];
  logic              r_busy;
  logic              r_done;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [IDX_W-1:0]  r_out_index;

  logic              w_in_fire;
  logic              w_out_fire;
  logic [ACC_W-1:0]  w_inc [NN];

  // Handshake: a word moves on any rising edge where valid && ready are both
  // high; in_ready and out_valid are registered and never high together.
  assign w_in_fire  = in_valid && r_in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  assign busy      = r_busy;
  assign done      = r_done;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_index = r_out_index;
  assign out_data  = r_acc[r_out_index];

  // PE(i,j) consumes k = t-i-j; at most one k matches per PE per cycle.
  always_comb begin
    for (int p = 0; p < NN; p++) w_inc[p] = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        for (int k = 0; k < N; k++)
          if (int'(r_t) == i + j + k)
            w_inc[i*N+j] = ACC_W'(PW'(r_a[i*N+k]) * PW'(r_b[k*N+j]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc_mode  <= 1'b0;
      r_cnt       <= '0;
      r_t         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_index <= '0;
      for (int p = 0; p < NN; p++) begin
        r_a[p]   <= '0;
        r_b[p]   <= '0;
        r_acc[p] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc_mode <= accumulate;
            r_state    <= S_LOAD_W;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
            r_cnt      <= '0;
          end
        end
        S_LOAD_W: begin
          if (w_in_fire) begin
            r_b[r_cnt] <= in_data;
            if (r_cnt == LAST_IDX) begin
              r_cnt   <= '0;
              r_state <= S_LOAD_A;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_LOAD_A: begin
          if (w_in_fire) begin
            r_a[r_cnt] <= in_data;
            if (r_cnt == LAST_IDX) begin
              r_cnt      <= '0;
              r_t        <= '0;
              r_in_ready <= 1'b0;
              r_state    <= S_COMPUTE;
              if (!r_acc_mode)
                for (int p = 0; p < NN; p++) r_acc[p] <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          for (int p = 0; p < NN; p++) r_acc[p] <= r_acc[p] + w_inc[p];
          if (r_t == LAST_T) begin
            r_t         <= '0;
            r_state     <= S_DRAIN;
            r_out_valid <= 1'b1;
            r_out_index <= '0;
          end else begin
            r_t <= r_t + 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_out_fire) begin
            if (r_out_index == LAST_IDX) begin
              r_out_valid <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_out_index <= r_out_index + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
